// File: rtl/cu_pkg.sv
// cu_pkg: state encoding and RV32I opcode constants for the control unit
package cu_pkg;
  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_INTR      = 3'd4
  } state_t;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/cu_wait_timer.sv
// cu_wait_timer: counts memory wait cycles and flags the last tolerated one
module cu_wait_timer #(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic fsm_rst,
  input  logic wait_en,
  input  logic clear,
  output logic expired
);
  localparam logic [TIMEOUT_W-1:0] LAST = {TIMEOUT_W{1'b1}} ^ TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] cnt;
  // cnt holds completed wait cycles; the current one makes 2^W-1 at LAST
  always_ff @(posedge clk)
    if (fsm_rst || clear) cnt <= '0;
    else if (wait_en) cnt <= cnt + 1'b1;
  assign expired = wait_en && (cnt == LAST);
endmodule

// File: rtl/cu_fsm_irq.sv
// cu_fsm_irq: multicycle RV32I control FSM with wait states, timeout and interrupt entry
module cu_fsm_irq
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter bit MEM_WAIT_EN = 1,
  parameter bit IRQ_EN      = 1,
  parameter int TIMEOUT_W   = 4
) (
  input  logic                clk,
  input  logic                fsm_rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic                intr,
  input  logic                mie,
  input  logic                mem_ready1,
  input  logic                mem_ready2,
  output logic                pc_write,
  output logic                reg_write,
  output logic                mem_WE2,
  output logic                mem_RDEN1,
  output logic                mem_RDEN2,
  output logic                pc_rst,
  output logic                csr_WE,
  output logic                int_taken,
  output logic                mret_exec,
  output logic                bus_err,
  output logic [2:0]          state_o
);
  state_t ps, ns, retire_ns;
  logic [6:0] op;
  logic r1, r2, is_sys, is_wr, waiting, rdy, expired;
  assign op = 7'(opcode);
  assign r1 = MEM_WAIT_EN ? mem_ready1 : 1'b1;
  assign r2 = MEM_WAIT_EN ? mem_ready2 : 1'b1;
  assign is_sys = op == OP_SYSTEM;
  assign is_wr = op inside {OP_RTYPE, OP_ITYPE, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
  assign retire_ns = (IRQ_EN && intr && mie) ? ST_INTR : ST_FETCH;
  assign waiting = ps == ST_FETCH || ps == ST_WRITEBACK || (ps == ST_EXECUTE && op == OP_STORE);
  assign rdy = ps == ST_FETCH ? r1 : r2;
  assign state_o = ps;
  cu_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk(clk),
    .fsm_rst(fsm_rst),
    .wait_en(waiting && !rdy),
    .clear(ns != ps || rdy),
    .expired(expired)
  );
  // present-state register
  always_ff @(posedge clk)
    if (fsm_rst) ps <= ST_INIT;
    else ps <= ns;
  // next state and enables; an expired wait overrides every enable with bus_err
  always_comb begin
    ns = ps;
    pc_write = 1'b0;
    reg_write = 1'b0;
    mem_WE2 = 1'b0;
    mem_RDEN1 = 1'b0;
    mem_RDEN2 = 1'b0;
    pc_rst = 1'b0;
    csr_WE = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    bus_err = 1'b0;
    if (expired) begin
      bus_err = 1'b1;
      ns = ST_INIT;
    end else
      case (ps)
        ST_INIT: begin
          pc_rst = 1'b1;
          ns = ST_FETCH;
        end
        ST_FETCH: begin
          mem_RDEN1 = 1'b1;
          ns = r1 ? ST_EXECUTE : ST_FETCH;
        end
        ST_EXECUTE:
          if (op == OP_LOAD) begin
            mem_RDEN2 = 1'b1;
            ns = ST_WRITEBACK;
          end else if (op == OP_STORE) begin
            mem_WE2 = 1'b1;
            pc_write = r2;
            ns = r2 ? retire_ns : ST_EXECUTE;
          end else begin
            pc_write = 1'b1;
            reg_write = is_wr || (is_sys && funct3 != 3'b000);
            csr_WE = is_sys && funct3 != 3'b000;
            mret_exec = is_sys && funct3 == 3'b000;
            ns = retire_ns;
          end
        ST_WRITEBACK: begin
          mem_RDEN2 = 1'b1;
          pc_write = r2;
          reg_write = r2;
          ns = r2 ? retire_ns : ST_WRITEBACK;
        end
        ST_INTR: begin
          int_taken = 1'b1;
          pc_write = 1'b1;
          ns = ST_FETCH;
        end
        default: ns = ST_INIT;
      endcase
  end
endmodule

// File: tb/tb_cu_fsm_irq.sv
// tb_cu_fsm_irq: directed checks of the control FSM across three parameter sets
module tb_cu_fsm_irq;
  localparam logic [12:0] PCW = 13'h1000, RW = 13'h0800, WE2 = 13'h0400, RD1 = 13'h0200,
                          RD2 = 13'h0100, PRST = 13'h0080, CSR = 13'h0040, INT = 13'h0020,
                          MRET = 13'h0010, BERR = 13'h0008;
  localparam logic [12:0] S_INIT = 13'd0, S_FETCH = 13'd1, S_EXEC = 13'd2, S_WB = 13'd3, S_INTR = 13'd4;
  localparam logic [6:0] RTYPE = 7'b0110011, ITYPE = 7'b0010011, LOAD = 7'b0000011,
                         STORE = 7'b0100011, SYS = 7'b1110011;
  logic clk = 1'b0, fsm_rst = 1'b1, intr = 1'b0, mie = 1'b0, r1 = 1'b1, r2 = 1'b1;
  logic [6:0] opcode = RTYPE;
  logic [2:0] funct3 = 3'b000;
  logic [12:0] v0, vt, vn;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  logic pw0, rw0, we0, rd10, rd20, pr0, cs0, it0, mr0, be0; logic [2:0] st0;
  logic pwt, rwt, wet, rd1t, rd2t, prt, cst, itt, mrt, bet; logic [2:0] stt;
  logic pwn, rwn, wen, rd1n, rd2n, prn, csn, itn, mrn, ben; logic [2:0] stn;
  cu_fsm_irq u0 (.clk(clk), .fsm_rst(fsm_rst), .opcode(opcode), .funct3(funct3), .intr(intr), .mie(mie),
    .mem_ready1(r1), .mem_ready2(r2), .pc_write(pw0), .reg_write(rw0), .mem_WE2(we0), .mem_RDEN1(rd10),
    .mem_RDEN2(rd20), .pc_rst(pr0), .csr_WE(cs0), .int_taken(it0), .mret_exec(mr0), .bus_err(be0), .state_o(st0));
  cu_fsm_irq #(.TIMEOUT_W(2)) ut (.clk(clk), .fsm_rst(fsm_rst), .opcode(opcode), .funct3(funct3), .intr(intr), .mie(mie),
    .mem_ready1(r1), .mem_ready2(r2), .pc_write(pwt), .reg_write(rwt), .mem_WE2(wet), .mem_RDEN1(rd1t),
    .mem_RDEN2(rd2t), .pc_rst(prt), .csr_WE(cst), .int_taken(itt), .mret_exec(mrt), .bus_err(bet), .state_o(stt));
  cu_fsm_irq #(.IRQ_EN(0)) un (.clk(clk), .fsm_rst(fsm_rst), .opcode(opcode), .funct3(funct3), .intr(intr), .mie(mie),
    .mem_ready1(r1), .mem_ready2(r2), .pc_write(pwn), .reg_write(rwn), .mem_WE2(wen), .mem_RDEN1(rd1n),
    .mem_RDEN2(rd2n), .pc_rst(prn), .csr_WE(csn), .int_taken(itn), .mret_exec(mrn), .bus_err(ben), .state_o(stn));
  assign v0 = {pw0, rw0, we0, rd10, rd20, pr0, cs0, it0, mr0, be0, st0};
  assign vt = {pwt, rwt, wet, rd1t, rd2t, prt, cst, itt, mrt, bet, stt};
  assign vn = {pwn, rwn, wen, rd1n, rd2n, prn, csn, itn, mrn, ben, stn};
  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick; tick;
    fsm_rst = 1'b0; #1;
    chk("rst_init", v0, PRST | S_INIT);
    tick; chk("alu_fetch", v0, RD1 | S_FETCH);
    tick; chk("alu_exec", v0, PCW | RW | S_EXEC);
    tick; chk("alu_fetch2", v0, RD1 | S_FETCH);
    tick; chk("alu_exec2", v0, PCW | RW | S_EXEC);
    tick; opcode = LOAD; #1; chk("ld_fetch", v0, RD1 | S_FETCH);
    tick; r2 = 1'b0; #1; chk("ld_exec", v0, RD2 | S_EXEC);
    tick; chk("ld_wb1", v0, RD2 | S_WB);
    tick; chk("ld_wb2", v0, RD2 | S_WB);
    tick; chk("ld_wb3", v0, RD2 | S_WB);
    tick; r2 = 1'b1; #1; chk("ld_wb4", v0, PCW | RW | RD2 | S_WB);
    tick; opcode = SYS; funct3 = 3'b000; #1; chk("ld_done", v0, RD1 | S_FETCH);
    tick; chk("mret", v0, PCW | MRET | S_EXEC);
    tick; funct3 = 3'b001;
    tick; chk("csr", v0, PCW | RW | CSR | S_EXEC);
    tick; opcode = 7'b0000000;
    tick; chk("unknown", v0, PCW | S_EXEC);
    tick; opcode = STORE; r2 = 1'b0; #1; chk("st_fetch", v0, RD1 | S_FETCH);
    tick; chk("st_wait1", v0, WE2 | S_EXEC);
    tick; chk("st_wait2", v0, WE2 | S_EXEC);
    tick; r2 = 1'b1; #1; chk("st_ready", v0, PCW | WE2 | S_EXEC);
    tick; opcode = ITYPE; mie = 1'b1; #1; chk("st_done", v0, RD1 | S_FETCH);
    tick; intr = 1'b1; #1; chk("irq_exec", v0, PCW | RW | S_EXEC);
    tick; chk("irq_entry", v0, PCW | INT | S_INTR);
    chk("irq_disabled", vn, RD1 | S_FETCH);
    intr = 1'b0;
    tick; chk("irq_fetch", v0, RD1 | S_FETCH);
    tick; intr = 1'b1; mie = 1'b0; #1; chk("mie0_exec", v0, PCW | RW | S_EXEC);
    tick; chk("mie0_fetch", v0, RD1 | S_FETCH);
    intr = 1'b1; mie = 1'b1; r1 = 1'b0;
    tick; intr = 1'b0; r1 = 1'b1;
    tick; chk("irq_drop_exec", v0, PCW | RW | S_EXEC);
    tick; chk("irq_drop_fetch", v0, RD1 | S_FETCH);
    fsm_rst = 1'b1;
    tick; fsm_rst = 1'b0; opcode = STORE; r2 = 1'b0;
    tick; chk("st2_fetch", v0, RD1 | S_FETCH);
    tick; chk("st2_wait1", v0, WE2 | S_EXEC);
    tick; fsm_rst = 1'b1;
    tick; #1; chk("midst_rst", v0, PRST | S_INIT);
    fsm_rst = 1'b0;
    tick; chk("midst_fetch", vt, RD1 | S_FETCH);
    tick; chk("to_st_w1", vt, WE2 | S_EXEC);
    tick; chk("to_st_w2", vt, WE2 | S_EXEC);
    tick; chk("to_st_w3", vt, BERR | S_EXEC);
    tick; chk("to_st_init", vt, PRST | S_INIT);
    fsm_rst = 1'b1; opcode = RTYPE; r2 = 1'b1;
    tick; fsm_rst = 1'b0; r1 = 1'b0; #1; chk("to_f_init", vt, PRST | S_INIT);
    tick; chk("to_f_w1", vt, RD1 | S_FETCH);
    tick; chk("to_f_w2", vt, RD1 | S_FETCH);
    tick; chk("to_f_w3", vt, BERR | S_FETCH);
    tick; chk("to_f_init2", vt, PRST | S_INIT);
    tick; chk("race_w1", vt, RD1 | S_FETCH);
    tick; chk("race_w2", vt, RD1 | S_FETCH);
    tick; r1 = 1'b1; #1; chk("race_w3", vt, RD1 | S_FETCH);
    tick; chk("race_exec", vt, PCW | RW | S_EXEC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
